// File: rtl/irq_arbiter_if.sv
// Peripheral bus port between the core and its memory-mapped blocks.
// Single-cycle access: a slave reacts in the cycle req is high.
interface arilla_bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: level gateways, priority select, claim/complete.
// Register window decode lives in periph_mem_interface below.
module periph_mem_interface #(
    parameter logic [31:0] BaseAddress = 32'h0,
    parameter int unsigned SizeWords   = 16
) (
    arilla_bus_if.slave                 bus,
    input  logic [SizeWords-1:0][31:0] data_periph_in,
    output logic [SizeWords-1:0]       wr_strobe,
    output logic [31:0]                data_periph_out,
    output logic                       hit
);
    localparam int unsigned AW = $clog2(SizeWords);

    logic [31:0]   offset;
    logic [AW-1:0] widx;

    // Addresses below the base wrap to a huge offset and miss.
    assign offset          = bus.addr - BaseAddress;
    assign widx            = offset[AW+1:2];
    assign hit             = offset < 32'(SizeWords * 4);
    assign data_periph_out = bus.wdata;
    assign bus.rdata       = hit ? data_periph_in[widx] : '0;

    // One-hot write strobe for the addressed word.
    always_comb begin
        wr_strobe = '0;
        for (int w = 0; w < int'(SizeWords); w++) begin
            wr_strobe[w] = bus.req && bus.we && hit && (widx == AW'(w));
        end
    end
endmodule

module irq_arbiter #(
    parameter logic [31:0] BaseAddress = 32'h0,
    parameter int unsigned NumSources  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NumSources-1:0] src,
    output logic                  irq,
    arilla_bus_if.slave           bus_interface,
    output logic                  hit
);
    localparam int N = int'(NumSources);

    localparam int OFF_ENABLE = 1;
    localparam int OFF_THRESH = 2;
    localparam int OFF_CLAIM  = 3;
    localparam int OFF_COMPL  = 4;
    localparam int OFF_PRIO   = 6;

    logic [N-1:0] pending;
    logic [N-1:0] in_service;
    logic [N-1:0] enable;
    logic [2:0]   threshold;
    logic [2:0]   prio [N];
    logic [5:0]   best_id;

    logic [N-1:0] pending_nxt;
    logic [N-1:0] in_service_nxt;
    logic [N-1:0] claim_vec;
    logic [N-1:0] comp_vec;

    logic         cand_found;
    logic [2:0]   cand_prio;
    logic [5:0]   cand_id;

    logic [15:0][31:0] rd_words;
    logic [15:0]       wr_strobe;
    logic [31:0]       wdata;
    logic [5:0]        wr_id;
    logic              unused_wdata;

    periph_mem_interface #(
        .BaseAddress (BaseAddress),
        .SizeWords   (16)
    ) u_mem (
        .bus             (bus_interface),
        .data_periph_in  (rd_words),
        .wr_strobe       (wr_strobe),
        .data_periph_out (wdata),
        .hit             (hit)
    );

    assign wr_id        = wdata[5:0];
    assign unused_wdata = ^wdata;

    // Claim/complete only act on a valid ID in the right state.
    always_comb begin
        claim_vec = '0;
        comp_vec  = '0;
        for (int i = 0; i < N; i++) begin
            claim_vec[i] = wr_strobe[OFF_CLAIM] && (wr_id == 6'(i + 1))
                           && pending[i];
            comp_vec[i]  = wr_strobe[OFF_COMPL] && (wr_id == 6'(i + 1))
                           && in_service[i];
        end
    end

    // Gateway: latch a level once, hold off while in service.
    always_comb begin
        pending_nxt    = pending;
        in_service_nxt = (in_service | claim_vec) & ~comp_vec;
        for (int i = 0; i < N; i++) begin
            if (claim_vec[i]) begin
                pending_nxt[i] = 1'b0;
            end else if (src[i] && !in_service[i]) begin
                pending_nxt[i] = 1'b1;
            end
        end
    end

    // Highest priority wins; strict compare keeps the lowest ID on ties.
    always_comb begin
        cand_found = 1'b0;
        cand_prio  = '0;
        cand_id    = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i] && enable[i] && (prio[i] > cand_prio)) begin
                cand_found = 1'b1;
                cand_prio  = prio[i];
                cand_id    = 6'(i + 1);
            end
        end
    end

    // Register map read view; absent fields stay zero.
    always_comb begin
        rd_words            = '0;
        rd_words[0]         = 32'(pending);
        rd_words[OFF_ENABLE] = 32'(enable);
        rd_words[OFF_THRESH] = 32'(threshold);
        rd_words[OFF_CLAIM]  = 32'(best_id);
        rd_words[5]         = 32'(in_service);
        for (int k = 0; k < N; k++) begin
            rd_words[OFF_PRIO + k / 8][4 * (k % 8) +: 3] = prio[k];
        end
    end

    // Arbiter state, config registers and the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending    <= '0;
            in_service <= '0;
            enable     <= '0;
            threshold  <= '0;
            best_id    <= '0;
            irq        <= 1'b0;
            for (int k = 0; k < N; k++) begin
                prio[k] <= '0;
            end
        end else begin
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
            best_id    <= cand_id;
            irq        <= cand_found && (cand_prio > threshold);
            if (wr_strobe[OFF_ENABLE]) begin
                enable <= wdata[N-1:0];
            end
            if (wr_strobe[OFF_THRESH]) begin
                threshold <= wdata[2:0];
            end
            for (int k = 0; k < N; k++) begin
                if (wr_strobe[OFF_PRIO + k / 8]) begin
                    prio[k] <= wdata[4 * (k % 8) +: 3];
                end
            end
        end
    end
endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed bus traffic, a per-cycle reference
// model of the arbiter rules, and literal expectations at key points.
module tb_irq_arbiter;
    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] src = '0;
    logic         irq;
    logic         hit;

    arilla_bus_if bus ();

    irq_arbiter #(
        .BaseAddress (BASE),
        .NumSources  (N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src           (src),
        .irq           (irq),
        .bus_interface (bus),
        .hit           (hit)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    bit m_pend  [1:N];
    bit m_insvc [1:N];
    bit m_en    [1:N];
    int m_prio  [1:N];
    int m_thr   = 0;
    int m_best  = 0;
    bit m_irq   = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd64);
    endfunction

    function automatic logic [31:0] mread(input int off);
        logic [31:0] v;
        v = '0;
        for (int id = 1; id <= N; id++) begin
            case (off)
                0: if (m_pend[id]) v[id-1] = 1'b1;
                1: if (m_en[id]) v[id-1] = 1'b1;
                5: if (m_insvc[id]) v[id-1] = 1'b1;
                6, 7, 8, 9:
                    if ((id - 1) / 8 == off - 6)
                        v = v | (32'(m_prio[id]) << (4 * ((id - 1) % 8)));
                default: ;
            endcase
        end
        if (off == 2) v = 32'(m_thr);
        if (off == 3) v = 32'(m_best);
        return v;
    endfunction

    // Reference model: pick max (prio, -id) among enabled pending
    // sources, then apply this cycle's bus write and the level inputs.
    int          s_best, s_bprio, s_score, s_bscore, s_off, s_id, s_cid, s_pid;
    logic [31:0] s_wv;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int id = 1; id <= N; id++) begin
                m_pend[id] = 0; m_insvc[id] = 0;
                m_en[id] = 0; m_prio[id] = 0;
            end
            m_thr = 0; m_best = 0; m_irq = 0;
        end else begin
            s_best = 0; s_bprio = 0; s_bscore = -1;
            for (int id = 1; id <= N; id++) begin
                if (m_pend[id] && m_en[id] && m_prio[id] > 0) begin
                    s_score = m_prio[id] * 64 + (63 - id);
                    if (s_score > s_bscore) begin
                        s_bscore = s_score; s_best = id; s_bprio = m_prio[id];
                    end
                end
            end
            m_irq  = (s_best != 0) && (s_bprio > m_thr);
            m_best = s_best;
            s_cid = 0; s_pid = 0;
            if (bus.req && bus.we && in_win(bus.addr)) begin
                s_off = int'((bus.addr - BASE) >> 2);
                s_wv  = bus.wdata;
                s_id  = int'(s_wv[5:0]);
                case (s_off)
                    1: for (int id = 1; id <= N; id++) m_en[id] = s_wv[id-1];
                    2: m_thr = int'(s_wv & 32'h7);
                    3: if (s_id >= 1 && s_id <= N && m_pend[s_id]) s_cid = s_id;
                    4: if (s_id >= 1 && s_id <= N && m_insvc[s_id]) s_pid = s_id;
                    6, 7, 8, 9:
                        for (int id = 1; id <= N; id++)
                            if ((id - 1) / 8 == s_off - 6)
                                m_prio[id] = int'((s_wv >> (4 * ((id - 1) % 8))) & 32'h7);
                    default: ;
                endcase
            end
            for (int id = 1; id <= N; id++) begin
                if (id == s_cid) begin
                    m_pend[id] = 0; m_insvc[id] = 1;
                end else if (id == s_pid) begin
                    m_insvc[id] = 0;
                end else if (!m_pend[id] && !m_insvc[id] && src[id-1]) begin
                    m_pend[id] = 1;
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("irq", 32'(irq), 32'(m_irq));
            check("hit", 32'(hit), 32'(in_win(bus.addr)));
            if (bus.req && !bus.we && in_win(bus.addr))
                check($sformatf("rd%0d", (bus.addr - BASE) >> 2),
                      bus.rdata, mread(int'((bus.addr - BASE) >> 2)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        bus.req = 1'b1; bus.we = 1'b1;
        bus.addr = BASE + 32'(off * 4); bus.wdata = d;
        cyc();
        bus.req = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input int off, input logic [31:0] exp, input string name);
        bus.req = 1'b1; bus.we = 1'b0;
        bus.addr = BASE + 32'(off * 4);
        @(negedge clk);
        check(name, bus.rdata, exp);
        check({name, "_hit"}, 32'(hit), 32'd1);
        cyc();
        bus.req = 1'b0;
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = BASE; bus.wdata = '0;
        rst_n = 1'b0; src = '1;
        cyc();
        chk_en = 1'b1;
        rd(0, 0, "rst_pend");
        rd(1, 0, "rst_en");
        rd(3, 0, "rst_claim");
        rd(5, 0, "rst_insvc");
        rd(6, 0, "rst_prio0");
        check("rst_irq", 32'(irq), 0);
        rst_n = 1'b1;
        cyc();
        rd(0, 32'hFF, "post_rst_pend");
        check("post_rst_irq", 32'(irq), 0);

        src = '0; rst_n = 1'b0; cyc(); rst_n = 1'b1;
        wr(6, 32'h3); wr(1, 32'h1); wr(2, 32'h0);
        src[0] = 1'b1; cyc(); src[0] = 1'b0;
        check("basic_irq_early", 32'(irq), 0);
        rd(0, 32'h1, "basic_pend");
        check("basic_irq", 32'(irq), 1);
        rd(3, 32'h1, "basic_claim");
        wr(3, 32'h1);
        rd(5, 32'h1, "basic_insvc");
        check("basic_irq_claimed", 32'(irq), 0);
        rd(0, 32'h0, "basic_pend_clr");
        wr(4, 32'h1);
        rd(5, 32'h0, "basic_complete");

        wr(6, 32'h0000_7550); wr(1, 32'h0E);
        src = 8'b0000_1110; cyc(); src = '0; cyc();
        rd(3, 32'd4, "arb_first");
        wr(3, 32'd4); cyc();
        rd(3, 32'd2, "arb_tie");
        wr(3, 32'd2); cyc();
        rd(3, 32'd3, "arb_third");
        wr(3, 32'd3); cyc();
        rd(3, 32'd0, "arb_empty");
        check("arb_irq_off", 32'(irq), 0);
        wr(4, 32'd4); wr(4, 32'd2); wr(4, 32'd3);
        rd(5, 32'h0, "arb_insvc_clr");

        wr(6, 32'h0002_0000); wr(1, 32'h10); wr(2, 32'd2);
        src[4] = 1'b1; cyc(); src[4] = 1'b0; cyc();
        rd(3, 32'd5, "thr_claim");
        check("thr_irq_blocked", 32'(irq), 0);
        wr(2, 32'd1); cyc();
        check("thr_irq", 32'(irq), 1);
        wr(6, 32'h0); cyc();
        rd(3, 32'd0, "prio0_claim");
        check("prio0_irq", 32'(irq), 0);

        wr(6, 32'h3); wr(1, 32'h1); wr(2, 32'h0);
        src[0] = 1'b1; cyc(); cyc();
        wr(3, 32'h1);
        rd(0, 32'h10, "rt_pend_claimed");
        cyc();
        rd(0, 32'h10, "rt_pend_hold");
        wr(4, 32'h1);
        rd(0, 32'h10, "rt_pend_c0");
        rd(0, 32'h11, "rt_pend_c1");
        src[0] = 1'b0;

        wr(3, 32'd6); wr(4, 32'd2); wr(3, 32'd40); wr(0, 32'h0); cyc();
        rd(0, 32'h11, "ill_pend");
        rd(5, 32'h0, "ill_insvc");
        rd(3, 32'h1, "ill_claim");
        check("ill_irq", 32'(irq), 1);
        for (int off = 10; off < 16; off++) rd(off, 32'h0, "hi_word");
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = BASE + 32'd64;
        @(negedge clk);
        check("miss_above", 32'(hit), 0);
        check("miss_rdata", bus.rdata, 0);
        bus.addr = BASE - 32'd4;
        @(negedge clk);
        check("miss_below", 32'(hit), 0);
        cyc(); bus.req = 1'b0;

        wr(1, 32'hFFFF_FFFF); rd(1, 32'hFF, "en_mask");
        wr(2, 32'hFFFF_FFFF); rd(2, 32'h7, "thr_mask");
        wr(7, 32'hFFFF_FFFF); rd(7, 32'h0, "prio1_mask");
        wr(6, 32'hFFFF_FFFF); rd(6, 32'h7777_7777, "prio0_mask");

        wr(2, 32'h0); wr(3, 32'h1);
        src[0] = 1'b1; rst_n = 1'b0; cyc(); rst_n = 1'b1;
        rd(0, 32'h0, "mid_rst_pend0");
        rd(0, 32'h1, "mid_rst_pend1");
        rd(5, 32'h0, "mid_rst_insvc");
        check("mid_rst_irq", 32'(irq), 0);
        src = '0; cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
